// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared types, default sizes and helpers for the reg_file_2r1w block.
//   - state_t   : clear-sequencer state (CLEAR while zeroing, RUN otherwise)
//   - *_DEF     : default data width, address width and entry count
//   - par_f     : even-parity bit of a data word (zero-extended to 64 bits)
//   Optional feature macro used by the block: REG_FILE_PARITY_EN.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int D_BUS_DEF = 32;
   localparam int A_BUS_DEF = 5;
   localparam int DEPTH_DEF = 32;

   // Even parity: the returned bit makes the total number of ones even.
   // Callers zero-extend their word, so data widths up to 64 bits are covered.
   function automatic logic par_f(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq
//   Clear sequencer for reg_file_2r1w. After reset, or when clr_i is seen,
//   it walks clr_cnt from 0 to DEPTH-1 issuing one zero-write per cycle,
//   then returns to RUN.
//   Ports:
//     clk_i      : clock
//     rst_ni     : asynchronous active-low reset (enters CLEAR, count 0)
//     clr_i      : request to restart the clear sequence
//     busy_o     : clear in progress (registered)
//     clr_we_o   : clear write enable for the array write port
//     clr_addr_o : entry currently being zeroed
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int A_BUS = A_BUS_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   output logic             busy_o,
   output logic             clr_we_o,
   output logic [A_BUS-1:0] clr_addr_o
);

   localparam logic [A_BUS-1:0] LAST_ADDR = A_BUS'(DEPTH - 1);

   state_t           state_q;
   logic [A_BUS-1:0] clr_cnt_q;
   logic             busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               if (clr_i) begin
                  // A new request restarts the walk from entry 0.
                  clr_cnt_q <= '0;
               end else if (clr_cnt_q == LAST_ADDR) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b0;
                  clr_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (clr_i) begin
                  state_q   <= CLEAR;
                  busy_q    <= 1'b1;
                  clr_cnt_q <= '0;
               end
            end
            default: begin
               state_q   <= CLEAR;
               busy_q    <= 1'b1;
               clr_cnt_q <= '0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign clr_we_o   = busy_q;
   assign clr_addr_o = clr_cnt_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
//   Register file with one write port and two registered read ports,
//   write-to-read bypass, optional hardwired-zero entry 0 and a built-in
//   clear sequencer that zeroes the array after reset or on CLR.
//   Ports:
//     CLK, RST_N        : clock, asynchronous active-low reset
//     CLR               : request to zero the whole array (wins over WE/RE)
//     WE, WADDR, WDATA  : write port
//     RE                : read enable shared by both read ports
//     RADDR_A, RADDR_B  : read addresses
//     RDATA_A, RDATA_B  : registered read data (1-cycle latency)
//     RVALID            : read data updated this cycle
//     BUSY              : clear sequence in progress
//     PERR_A, PERR_B    : stored-parity mismatch flags (only with
//                         REG_FILE_PARITY_EN defined)
//   Optional feature macro: REG_FILE_PARITY_EN adds a parity bit per entry.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int D_BUS   = D_BUS_DEF,
   parameter int A_BUS   = A_BUS_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CLR,
   input  logic             WE,
   input  logic [A_BUS-1:0] WADDR,
   input  logic [D_BUS-1:0] WDATA,
   input  logic             RE,
   input  logic [A_BUS-1:0] RADDR_A,
   input  logic [A_BUS-1:0] RADDR_B,
   output logic [D_BUS-1:0] RDATA_A,
   output logic [D_BUS-1:0] RDATA_B,
`ifdef REG_FILE_PARITY_EN
   output logic             PERR_A,
   output logic             PERR_B,
`endif
   output logic             RVALID,
   output logic             BUSY
);

`ifdef REG_FILE_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int EW = D_BUS + PAR_W;
   // One extra bit so DEPTH == 2**A_BUS is representable.
   localparam logic [A_BUS:0] DEPTH_W = (A_BUS + 1)'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];

   logic             busy;
   logic             clr_we;
   logic [A_BUS-1:0] clr_addr;

   reg_file_clr_seq #(
      .A_BUS (A_BUS),
      .DEPTH (DEPTH)
   ) u_clr_seq (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .clr_i      (CLR),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // Entry is real storage: in range and not the hardwired zero register.
   function automatic logic addr_ok(input logic [A_BUS-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !(R0_ZERO && (a == '0));
   endfunction

   logic run_ok, wr_ok, rd_ok;
   assign run_ok = !busy && !CLR;
   assign wr_ok  = run_ok && WE && addr_ok(WADDR);
   assign rd_ok  = run_ok && RE;

   // Write port: the clear sequencer owns it while busy, writeback otherwise.
   logic             mem_we;
   logic [A_BUS-1:0] mem_waddr;
   logic [EW-1:0]    mem_wdata;
   logic [EW-1:0]    wr_entry;

`ifdef REG_FILE_PARITY_EN
   assign wr_entry = {par_f(64'(WDATA)), WDATA};
`else
   assign wr_entry = WDATA;
`endif

   assign mem_we    = clr_we || wr_ok;
   assign mem_waddr = clr_we ? clr_addr : WADDR;
   assign mem_wdata = clr_we ? '0 : wr_entry;

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Read lookup for both ports, with bypass from a same-cycle write.
   logic [1:0][A_BUS-1:0] raddr;
   logic [1:0][D_BUS-1:0] rdata_d, rdata_q;
   logic [1:0]            perr_d, perr_q;
   logic                  rvalid_q;
   logic [EW-1:0]         rd_entry;

   assign raddr = {RADDR_B, RADDR_A};

   always_comb begin
      rdata_d  = '0;
      perr_d   = '0;
      rd_entry = '0;
      for (int p = 0; p < 2; p++) begin
         if (addr_ok(raddr[p])) begin
            if (wr_ok && (WADDR == raddr[p])) begin
               rdata_d[p] = WDATA;
            end else begin
               rd_entry   = mem_q[raddr[p]];
               rdata_d[p] = rd_entry[D_BUS-1:0];
`ifdef REG_FILE_PARITY_EN
               perr_d[p]  = rd_entry[D_BUS] != par_f(64'(rd_entry[D_BUS-1:0]));
`endif
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata_q  <= '0;
         perr_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_ok;
         if (rd_ok) begin
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
         end
      end
   end

   assign RDATA_A = rdata_q[0];
   assign RDATA_B = rdata_q[1];
   assign RVALID  = rvalid_q;
   assign BUSY    = busy;
`ifdef REG_FILE_PARITY_EN
   assign PERR_A  = perr_q[0];
   assign PERR_B  = perr_q[1];
`else
   // Parity flags only exist in the parity build.
   logic unused_perr;
   assign unused_perr = ^perr_q;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w (default parameters: 32 x 32, R0 hardwired zero).
module tb_reg_file_2r1w;

   localparam int DEPTH = 32;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CLR = 1'b0;
   logic        WE = 1'b0;
   logic [4:0]  WADDR = '0;
   logic [31:0] WDATA = '0;
   logic        RE = 1'b0;
   logic [4:0]  RADDR_A = '0;
   logic [4:0]  RADDR_B = '0;
   logic [31:0] RDATA_A, RDATA_B;
   logic        RVALID, BUSY;
`ifdef REG_FILE_PARITY_EN
   logic        PERR_A, PERR_B;
`endif

   reg_file_2r1w dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .CLR     (CLR),
      .WE      (WE),
      .WADDR   (WADDR),
      .WDATA   (WDATA),
      .RE      (RE),
      .RADDR_A (RADDR_A),
      .RADDR_B (RADDR_B),
      .RDATA_A (RDATA_A),
      .RDATA_B (RDATA_B),
`ifdef REG_FILE_PARITY_EN
      .PERR_A  (PERR_A),
      .PERR_B  (PERR_B),
`endif
      .RVALID  (RVALID),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   // Reference model: contents as the architecture sees them.
   logic [31:0] m_mem [DEPTH];
   bit          m_corrupt [DEPTH];
   int          busy_left;
   logic [31:0] e_a, e_b;
   logic        e_v, e_pa, e_pb;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (WE && WADDR == a) return WDATA;
      return m_mem[a];
   endfunction

   function automatic logic m_perr(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (WE && WADDR == a) return 1'b0;
      return m_corrupt[a];
   endfunction

   task automatic m_reset();
      busy_left = DEPTH;
      e_a = '0; e_b = '0; e_v = 1'b0; e_pa = 1'b0; e_pb = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_corrupt[i] = 1'b0;
      end
   endtask

   // Model of one clock edge, using the inputs as sampled at that edge.
   task automatic m_edge();
      e_v = 1'b0;
      if (busy_left > 0) begin
         if (CLR) busy_left = DEPTH;
         else busy_left--;
      end else if (CLR) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_corrupt[i] = 1'b0;
         end
         busy_left = DEPTH;
      end else begin
         if (RE) begin
            e_a = m_rd(RADDR_A); e_b = m_rd(RADDR_B);
            e_pa = m_perr(RADDR_A); e_pb = m_perr(RADDR_B);
            e_v = 1'b1;
         end
         if (WE && WADDR != 0) begin
            m_mem[WADDR] = WDATA;
            m_corrupt[WADDR] = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("busy", BUSY, (busy_left != 0));
      chk("rvalid", RVALID, e_v);
      chk("rdata_a", RDATA_A, e_a);
      chk("rdata_b", RDATA_B, e_b);
`ifdef REG_FILE_PARITY_EN
      chk("perr_a", PERR_A, e_pa);
      chk("perr_b", PERR_B, e_pb);
`endif
   endtask

   task automatic step(input bit clr, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit re, input logic [4:0] ra, input logic [4:0] rb);
      CLR = clr; WE = we; WADDR = wa; WDATA = wd; RE = re; RADDR_A = ra; RADDR_B = rb;
      @(posedge CLK);
      m_edge();
      #1;
      check_outputs();
      $display("t=%0t clr=%0b we=%0b wa=%0d wd=%08h re=%0b ra=%0d rb=%0d -> busy=%0b rv=%0b a=%08h b=%08h",
               $time, clr, we, wa, wd, re, ra, rb, BUSY, RVALID, RDATA_A, RDATA_B);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
   endtask

   // Run random (ignored) traffic while BUSY; the clear must last DEPTH cycles.
   task automatic wait_clear(input string tag);
      int n = 0;
      while (BUSY && n < 200) begin
         step(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b1,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         n++;
      end
      chk(tag, n, DEPTH);
   endtask

   initial begin
      m_reset();
      // Reset held for 3 cycles.
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", BUSY, 1);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rdata_a", RDATA_A, 0);
      chk("rst_rdata_b", RDATA_B, 0);
      RST_N = 1'b1;
      m_reset();
      wait_clear("busy_len_reset");

      // Whole array reads zero after the initial clear.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
      idle();

      // Basic write then read.
      step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
      chk("basic_a", RDATA_A, 32'hDEADBEEF);
      chk("basic_b", RDATA_B, 32'h0);
      idle();

      // Bypass on both ports.
      step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 5'd7);
      chk("bypass_a", RDATA_A, 32'h12345678);
      chk("bypass_b", RDATA_B, 32'h12345678);

      // Entry 0 ignores writes and never bypasses.
      step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7);
      chk("r0_read", RDATA_A, 32'h0);
      step(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 5'd0, 5'd0);
      chk("r0_bypass", RDATA_A, 32'h0);

      // CLR wins over a same-cycle write; clear takes DEPTH cycles.
      step(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0);
      step(1'b1, 1'b1, 5'd3, 32'h00000001, 1'b1, 5'd9, 5'd3);
      wait_clear("busy_len_clr");
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd9);
      chk("clr_r3", RDATA_A, 32'h0);
      chk("clr_r9", RDATA_B, 32'h0);

      // Reset pulsed mid-clear with non-zero read data held.
      step(1'b0, 1'b1, 5'd9, 32'h5A5A5A5A, 1'b0, 5'd0, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      repeat (9) idle();
      RST_N = 1'b0;
      #1;
      chk("midrst_busy", BUSY, 1);
      chk("midrst_rvalid", RVALID, 0);
      chk("midrst_rdata_a", RDATA_A, 0);
      chk("midrst_rdata_b", RDATA_B, 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      m_reset();
      wait_clear("busy_len_midrst");
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5);
      chk("midrst_r9", RDATA_A, 32'h0);

`ifdef REG_FILE_PARITY_EN
      // Corrupt a stored bit and expect the parity flag on that port only.
      step(1'b0, 1'b1, 5'd4, 32'h0000000F, 1'b0, 5'd0, 5'd0);
      step(1'b0, 1'b1, 5'd5, 32'h00000003, 1'b0, 5'd0, 5'd0);
      idle();
      dut.mem_q[4][0] = ~dut.mem_q[4][0];
      m_mem[4] = m_mem[4] ^ 32'h1;
      m_corrupt[4] = 1'b1;
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5);
      chk("par_perr_a", PERR_A, 1);
      chk("par_perr_b", PERR_B, 0);
      chk("par_rvalid", RVALID, 1);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
